pll_drp_sequencer: RTL

// - Reconfigures a PLLE4_ADV at run time through its DRP: holds the PLL in reset, applies one preset (masked read-modify-write per register), releases reset, waits for stable lock.
// - Sits between board reset/user logic and the PLL; out_rst gates downstream domain reset synchronisers.

---
 rtl/pll_drp_pkg.sv | 50 +++++
 rtl/pll_lock_sync.sv | 41 ++++
 rtl/pll_drp_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pll_drp_pkg.sv
// Shared types, state encoding and the preset table for the PLLE4 DRP reconfiguration sequencer.
// The table holds CLKFBOUT/CLKOUT0/CLKOUT1 divider registers plus two loop-filter registers per preset.
package pll_drp_pkg;

  localparam int HOLD_CYCLES = 4;
  localparam int DRP_AW      = 7;
  localparam int DRP_DW      = 16;

  typedef struct packed {
    logic [DRP_AW-1:0] addr;
    logic [DRP_DW-1:0] mask;
    logic [DRP_DW-1:0] data;
  } drp_entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_RELEASE,
    ST_LOCK_WAIT,
    ST_RETRY
  } state_t;

  // Divider words are {PHASE_MUX/RSVD, HIGH_TIME[11:6], LOW_TIME[5:0]}; reg2 holds EDGE[7]/NO_COUNT[6].
  function automatic drp_entry_t drp_rom(input logic [1:0] cfg, input logic [2:0] idx);
    drp_entry_t e;
    logic [15:0] fb1, o0_1, o0_2, o1_1, o1_2, flt;
    case (cfg)
      2'd0:    begin fb1 = 16'h0104; o0_1 = 16'h0082; o0_2 = 16'h0000; o1_1 = 16'h0104; o1_2 = 16'h0000; flt = 16'h0900; end
      2'd1:    begin fb1 = 16'h0145; o0_1 = 16'h0145; o0_2 = 16'h0000; o1_1 = 16'h00C2; o1_2 = 16'h0080; flt = 16'h1800; end
      2'd2:    begin fb1 = 16'h0104; o0_1 = 16'h00C3; o0_2 = 16'h0000; o1_1 = 16'h0186; o1_2 = 16'h0000; flt = 16'h0900; end
      default: begin fb1 = 16'h0186; o0_1 = 16'h0041; o0_2 = 16'h0040; o1_1 = 16'h0082; o1_2 = 16'h0000; flt = 16'h8100; end
    endcase
    case (idx)
      3'd0:    e = '{addr: 7'h14, mask: 16'h0FFF, data: fb1};
      3'd1:    e = '{addr: 7'h15, mask: 16'h00C0, data: 16'h0000};
      3'd2:    e = '{addr: 7'h08, mask: 16'h0FFF, data: o0_1};
      3'd3:    e = '{addr: 7'h09, mask: 16'h00C0, data: o0_2};
      3'd4:    e = '{addr: 7'h0A, mask: 16'h0FFF, data: o1_1};
      3'd5:    e = '{addr: 7'h0B, mask: 16'h00C0, data: o1_2};
      3'd6:    e = '{addr: 7'h4E, mask: 16'h9900, data: flt};
      default: e = '{addr: 7'h4F, mask: 16'h0000, data: 16'h0000};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Brings the asynchronous PLL LOCKED into clk with two flops and counts consecutive locked cycles.
// lock_stable fires on the cycle the run of locked cycles reaches LOCK_STABLE while counting is enabled.
module pll_lock_sync #(
  parameter int LOCK_STABLE = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_locked,
  input  logic i_en,
  output logic o_lock_stable,
  output logic o_lock_lost
);

  localparam int CNTW = $clog2(LOCK_STABLE + 1);

  logic            r_meta;
  logic            r_sync;
  logic [CNTW-1:0] r_cnt;
  logic            w_at_limit;

  assign w_at_limit    = (r_cnt == CNTW'(LOCK_STABLE - 1));
  assign o_lock_stable = i_en & r_sync & w_at_limit;
  assign o_lock_lost   = ~r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_locked;
      r_sync <= r_meta;
      if (!i_en || !r_sync) begin
        r_cnt <= '0;
      end else if (!w_at_limit) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_drp_sequencer.sv
// Run-time PLLE4 reconfiguration: hold PLL in reset, masked read-modify-write of one preset over DRP,
// release, wait for stable lock. Define PLL_LOCK_WATCHDOG_EN to add the lock-timeout retry watchdog.
module pll_drp_sequencer
  import pll_drp_pkg::*;
#(
  parameter int NUM_CFG      = 4,
  parameter int ENTRIES      = 8,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  localparam int CW          = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_req,
  input  logic [CW-1:0]     i_cfg_sel,
  output logic              o_busy,
  output logic              o_out_rst,
  output logic              o_err,
  output logic              o_pll_rst,
  input  logic              i_pll_locked,
  output logic [DRP_AW-1:0] o_daddr,
  output logic              o_den,
  output logic              o_dwe,
  output logic [DRP_DW-1:0] o_di,
  input  logic [DRP_DW-1:0] i_dout,
  input  logic              i_drdy
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES);

  state_t            r_state, w_state_next;
  logic [IW-1:0]     r_idx, w_idx_next;
  logic [CW-1:0]     r_cfg, w_cfg_next;
  logic [HW-1:0]     r_hold_cnt, w_hold_next;
  logic              r_busy, w_busy_next;
  logic              r_out_rst, w_out_rst_next;
  logic              r_err, w_err_next;
  logic              r_pll_rst, w_pll_rst_next;
  logic              r_den, w_den_next;
  logic              r_dwe, w_dwe_next;
  logic [DRP_AW-1:0] r_daddr, w_daddr_next;
  logic [DRP_DW-1:0] r_di, w_di_next;
  drp_entry_t        w_entry;
  logic              w_lock_stable;
  logic              w_lock_lost;
  logic              w_timeout;

  pll_lock_sync #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_sync (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_locked      (i_pll_locked),
    .i_en          (r_state == ST_LOCK_WAIT),
    .o_lock_stable (w_lock_stable),
    .o_lock_lost   (w_lock_lost)
  );

`ifdef PLL_LOCK_WATCHDOG_EN
  logic [16:0] r_wd_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != ST_LOCK_WAIT) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_wd_cnt == 17'(LOCK_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_cfg_next     = r_cfg;
    w_hold_next    = r_hold_cnt;
    w_out_rst_next = r_out_rst;
    w_err_next     = r_err;
    case (r_state)
      ST_IDLE: begin
        if (i_cfg_req) begin
          w_state_next   = ST_HOLD;
          w_cfg_next     = i_cfg_sel;
          w_err_next     = 1'b0;
          w_idx_next     = '0;
          w_hold_next    = '0;
          w_out_rst_next = 1'b1;
        end else if (w_lock_lost) begin
          w_state_next   = ST_RELEASE;
          w_out_rst_next = 1'b1;
        end
      end
      ST_HOLD, ST_RETRY: begin
        if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          w_state_next = (r_state == ST_HOLD) ? ST_RD : ST_RELEASE;
        end else begin
          w_hold_next = r_hold_cnt + 1'b1;
        end
      end
      ST_RD:      w_state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (i_drdy) w_state_next = ST_WR;
      ST_WR:      w_state_next = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (i_drdy) begin
          if (r_idx == IW'(ENTRIES - 1)) begin
            w_state_next = ST_RELEASE;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_state_next = ST_RD;
          end
        end
      end
      ST_RELEASE: w_state_next = ST_LOCK_WAIT;
      ST_LOCK_WAIT: begin
        if (w_lock_stable) begin
          w_state_next   = ST_IDLE;
          w_out_rst_next = 1'b0;
        end else if (w_timeout) begin
          w_state_next = ST_RETRY;
          w_hold_next  = '0;
          w_err_next   = 1'b1;
        end
      end
      default: w_state_next = ST_RELEASE;
    endcase

    // Index only advances out of WR_WAIT, so during RD_WAIT this is still the current entry.
    w_entry = drp_rom(2'(r_cfg), 3'(w_idx_next));

    w_busy_next    = (w_state_next != ST_IDLE);
    w_pll_rst_next = (w_state_next == ST_HOLD)    || (w_state_next == ST_RD) ||
                     (w_state_next == ST_RD_WAIT) || (w_state_next == ST_WR) ||
                     (w_state_next == ST_WR_WAIT) || (w_state_next == ST_RETRY);
    w_den_next     = (w_state_next == ST_RD) || (w_state_next == ST_WR);
    w_dwe_next     = (w_state_next == ST_WR);
    w_daddr_next   = (w_state_next == ST_RD) ? w_entry.addr : r_daddr;
    w_di_next      = r_di;
    if (r_state == ST_RD_WAIT && i_drdy) begin
      w_di_next = (i_dout & ~w_entry.mask) | (w_entry.data & w_entry.mask);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_RELEASE;
      r_idx      <= '0;
      r_cfg      <= '0;
      r_hold_cnt <= '0;
      r_busy     <= 1'b1;
      r_out_rst  <= 1'b1;
      r_err      <= 1'b0;
      r_pll_rst  <= 1'b1;
      r_den      <= 1'b0;
      r_dwe      <= 1'b0;
      r_daddr    <= '0;
      r_di       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_cfg      <= w_cfg_next;
      r_hold_cnt <= w_hold_next;
      r_busy     <= w_busy_next;
      r_out_rst  <= w_out_rst_next;
      r_err      <= w_err_next;
      r_pll_rst  <= w_pll_rst_next;
      r_den      <= w_den_next;
      r_dwe      <= w_dwe_next;
      r_daddr    <= w_daddr_next;
      r_di       <= w_di_next;
    end
  end

  assign o_busy    = r_busy;
  assign o_out_rst = r_out_rst;
  assign o_err     = r_err;
  assign o_pll_rst = r_pll_rst;
  assign o_den     = r_den;
  assign o_dwe     = r_dwe;
  assign o_daddr   = r_daddr;
  assign o_di      = r_di;

endmodule
